// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: arbiter states,
// grant owner encoding and default bus widths.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_DATA,
        GRANT_FETCH
    } grant_t;

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// Bus watchdog counter. clear zeroes it, enable counts a waiting cycle.
// expired is high in the cycle whose count step reaches TIMEOUT_CYC.
// Ports: clk, nrst, clear, enable -> expired.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LIMIT so a stuck enable never wraps to a fresh window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates data-memory and instruction-fetch requests onto one bus.
// Ports: d_* data side, i_* fetch side, bus_* external bus, bus_err watchdog.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_good,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_adr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_good,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_adr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;

    logic              busy;
    logic              expired;
    logic              data_req;
    logic [DATA_W-1:0] cap_data;

    assign busy     = (state_q == DATA) || (state_q == FETCH);
    assign data_req = d_read || d_write;

    mem_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .nrst   (nrst),
        .clear  (state_q == IDLE),
        .enable (busy && !bus_ack),
        .expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
        bus_read_d   = bus_read_q;
        bus_write_d  = bus_write_q;
        d_rdata_d    = d_rdata_q;
        i_data_d     = i_data_q;
        // A timed-out transaction returns zero data.
        cap_data     = bus_ack ? bus_rdata : '0;

        unique case (state_q)
            IDLE: begin
                // Contention goes to whichever side did not win last time.
                if (data_req &&
                    (!i_read || (last_grant_q == GRANT_FETCH))) begin
                    state_d      = DATA;
                    last_grant_d = GRANT_DATA;
                    adr_d        = d_adr;
                    wdata_d      = d_wdata;
                    // Write wins when both read and write are raised.
                    bus_write_d  = d_write;
                    bus_read_d   = !d_write;
                end else if (i_read) begin
                    state_d      = FETCH;
                    last_grant_d = GRANT_FETCH;
                    adr_d        = i_adr;
                    bus_write_d  = 1'b0;
                    bus_read_d   = 1'b1;
                end
            end
            DATA, FETCH: begin
                if (bus_ack || expired) begin
                    state_d     = RESP;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    if (state_q == DATA) begin
                        d_rdata_d = cap_data;
                    end else begin
                        i_data_d = cap_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FETCH;
            adr_q        <= '0;
            wdata_q      <= '0;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            d_rdata_q    <= '0;
            i_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            bus_read_q   <= bus_read_d;
            bus_write_q  <= bus_write_d;
            d_rdata_q    <= d_rdata_d;
            i_data_q     <= i_data_d;
        end
    end

    // last_grant names the owner of the transaction being answered in RESP.
    assign d_good    = (state_q == RESP) && (last_grant_q == GRANT_DATA);
    assign i_good    = (state_q == RESP) && (last_grant_q == GRANT_FETCH);
    assign bus_err   = expired;
    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign bus_adr   = adr_q;
    assign bus_wdata = wdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_data    = i_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an expected-response queue.
// Drives at posedge+1, samples at posedge+2 or later.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    typedef struct {
        bit          fetch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_adr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_good;
    logic        i_read = 1'b0;
    logic [31:0] i_adr = '0;
    logic [31:0] i_data;
    logic        i_good;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'hBAD0_0000;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_adr    (d_adr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_good   (d_good),
        .i_read   (i_read),
        .i_adr    (i_adr),
        .i_data   (i_data),
        .i_good   (i_good),
        .bus_read (bus_read),
        .bus_write(bus_write),
        .bus_adr  (bus_adr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction starting in an IDLE cycle (cycle 0). ack_at==0 means
    // the bus never answers and the watchdog must fire at cycle TMO.
    // both raises the other requester too; it stays high for the next call.
    task automatic txn(input bit fetch, input bit rd, input bit wr,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rdata,
                       input bit both);
        int   last;
        exp_t e;
        last = (ack_at == 0) ? TMO : ack_at;
        if (fetch) begin
            i_read = 1'b1;
            i_adr  = adr;
        end else begin
            d_read  = rd;
            d_write = wr;
            d_adr   = adr;
            d_wdata = wd;
        end
        if (both && fetch) begin
            d_read = 1'b1;
            d_adr  = 32'h0000_2000;
        end
        if (both && !fetch) begin
            i_read = 1'b1;
            i_adr  = 32'h0000_0044;
        end
        e.fetch = fetch;
        e.data  = (ack_at == 0) ? 32'h0 : rdata;
        sb.push_back(e);
        #1;
        chk("c0_strobes", 64'({bus_read, bus_write}), 64'(0));
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            bus_ack   = (c == ack_at);
            bus_rdata = (c == ack_at) ? rdata : (32'hBAD0_0000 | 32'(c));
            #1;
            chk("strobe_rd", 64'(bus_read), 64'(fetch || !wr));
            chk("strobe_wr", 64'(bus_write), 64'(!fetch && wr));
            chk("bus_adr", 64'(bus_adr), 64'(adr));
            if (!fetch && wr) chk("bus_wdata", 64'(bus_wdata), 64'(wd));
            chk("bus_err", 64'(bus_err), 64'(ack_at == 0 && c == TMO));
            chk("early_good", 64'({d_good, i_good}), 64'(0));
        end
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'hBAD0_0000;
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("good_d", 64'(d_good), 64'(!e.fetch));
            chk("good_i", 64'(i_good), 64'(e.fetch));
            chk("resp_data", 64'(e.fetch ? i_data : d_rdata), 64'(e.data));
        end
        chk("resp_bus", 64'({bus_read, bus_write, bus_err}), 64'(0));
        if (fetch) begin
            i_read = 1'b0;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("idle_good", 64'({d_good, i_good}), 64'(0));
        chk("idle_strobes", 64'({bus_read, bus_write}), 64'(0));
    endtask

    initial begin
        // Reset with both requesters already asking.
        d_read = 1'b1;
        d_adr  = 32'h0000_2000;
        i_read = 1'b1;
        i_adr  = 32'h0000_0044;
        #12;
        chk("rst_strobes", 64'({bus_read, bus_write, bus_err}), 64'(0));
        chk("rst_good", 64'({d_good, i_good}), 64'(0));
        chk("rst_adr", 64'(bus_adr), 64'(0));
        chk("rst_wdata", 64'(bus_wdata), 64'(0));
        chk("rst_rdata", 64'({d_rdata, i_data}), 64'(0));
        #10;
        nrst = 1'b1;

        // Contention: data first after reset, then strict alternation.
        txn(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 2, 32'h1111_0001, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h2222_0002, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1, 32'h3333_0003, 1'b1);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 3, 32'h4444_0004, 1'b0);

        // Plain fetch, ack at cycle 3.
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'h0051_0093, 1'b0);
        // Write with single-cycle ack.
        txn(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1,
            32'h1234_5678, 1'b0);
        // Watchdog expiry, then ack exactly on the expiry cycle.
        txn(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 0, 32'h5555_5555, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h0000_5004, 32'h0, TMO, 32'h6666_0006,
            1'b0);
        // Read and write together behave as a write.
        txn(1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2,
            32'h7777_0007, 1'b0);

        // Reset in the middle of a fetch.
        @(posedge clk);
        #1;
        i_read = 1'b1;
        i_adr  = 32'h0000_0080;
        @(posedge clk);
        #2;
        chk("mid_c1_read", 64'(bus_read), 64'(1));
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("mid_async_read", 64'(bus_read), 64'(0));
        chk("mid_no_good", 64'({d_good, i_good}), 64'(0));
        chk("mid_idata_clr", 64'(i_data), 64'(0));
        i_read = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_hold", 64'({bus_read, bus_write, bus_err, d_good, i_good}),
            64'(0));
        nrst = 1'b1;
        txn(1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0, 2, 32'h0000_0013, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
